ssl_sched: RTL and testbench

- Frame scheduler for the sound-source-localisation datapath.
- Sequences one time-difference estimate per frame in three steps:
  - captures NDATA 4-channel samples into the external sample buffer;
  - sweeps a shared external correlator over three mic pairs (A: mic0–mic1, B: mic0–mic2, C: mic0–mic3) and every lag 0..NDATA-1;
  - tracks the argmax lag per pair and publishes dIdA/dIdB/dIdC with a valid/ready handshake.

---
 rtl/ssl_pkg.sv | 22 ++
 rtl/ssl_sched_if.sv | 40 ++++
 rtl/ssl_argmax.sv | 44 ++++
 rtl/ssl_sched.sv | 146 ++++++++++++++
 tb/tb_ssl_sched.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssl_pkg.sv
// Shared types and constants for the sound-source-localisation frame scheduler.
package ssl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [1:0] PAIR_A = 2'd0;  // mic0-mic1
    localparam logic [1:0] PAIR_B = 2'd1;  // mic0-mic2
    localparam logic [1:0] PAIR_C = 2'd2;  // mic0-mic3
    localparam int NPAIR   = 3;
    localparam int SCORE_W = 16;

    function automatic int ndata_log(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/ssl_sched_if.sv
// Scheduler-side bundle: control, sample buffer, correlator and result handshake.
interface ssl_sched_if import ssl_pkg::*; #(
    parameter int NDATA = 128,
    parameter int SW    = SCORE_W
);
    localparam int NL = ndata_log(NDATA);

    logic                 start;
    logic                 cont;
    logic                 abort;
    logic                 wr_en;
    logic [NL-1:0]        wr_addr;
    logic [NL-1:0]        rd_addr;
    logic [NL-1:0]        lag;
    logic [1:0]           pair_sel;
    logic                 acc_en;
    logic                 acc_clr;
    logic                 acc_last;
    logic signed [SW-1:0] corr_score;
    logic                 corr_valid;
    logic                 busy;
    logic                 res_valid;
    logic                 res_ready;
    logic [NL-1:0]        dIdA;
    logic [NL-1:0]        dIdB;
    logic [NL-1:0]        dIdC;

    modport slave (
        input  start, cont, abort, corr_score, corr_valid, res_ready,
        output wr_en, wr_addr, rd_addr, lag, pair_sel, acc_en, acc_clr, acc_last,
               busy, res_valid, dIdA, dIdB, dIdC
    );

    modport master (
        output start, cont, abort, corr_score, corr_valid, res_ready,
        input  wr_en, wr_addr, rd_addr, lag, pair_sel, acc_en, acc_clr, acc_last,
               busy, res_valid, dIdA, dIdB, dIdC
    );

endinterface

// File: rtl/ssl_argmax.sv
// Per-pair running maximum of correlator scores; lag 0 always reloads so a new
// frame never inherits a stale best.
module ssl_argmax import ssl_pkg::*; #(
    parameter int NL = 7,
    parameter int SW = SCORE_W
) (
    input  logic                       clk,
    input  logic                       erst,
    input  logic                       corr_valid_i,
    input  logic signed [SW-1:0]       corr_score_i,
    input  logic [1:0]                 pair_d_i,
    input  logic [NL-1:0]              lag_d_i,
    output logic [NPAIR-1:0][NL-1:0]   best_lag_o
);

    logic [NPAIR-1:0][SW-1:0] score_q, score_d;
    logic [NPAIR-1:0][NL-1:0] blag_q, blag_d;

    // Strict greater-than keeps the lowest lag among equal scores.
    always_comb begin
        score_d = score_q;
        blag_d  = blag_q;
        for (int p = 0; p < NPAIR; p++) begin
            if (corr_valid_i && pair_d_i == 2'(p) &&
                (lag_d_i == '0 || corr_score_i > $signed(score_q[p]))) begin
                score_d[p] = corr_score_i;
                blag_d[p]  = lag_d_i;
            end
        end
    end

    always_ff @(posedge clk or negedge erst) begin
        if (!erst) begin
            score_q <= '0;
            blag_q  <= '0;
        end else begin
            score_q <= score_d;
            blag_q  <= blag_d;
        end
    end

    assign best_lag_o = blag_q;

endmodule

// File: rtl/ssl_sched.sv
// Frame scheduler: capture NDATA samples, sweep the correlator over 3 pairs x
// NDATA lags x NDATA terms, then publish the argmax lag of each pair.
module ssl_sched import ssl_pkg::*; #(
    parameter int NDATA = 128,
    parameter int SW    = SCORE_W
) (
    input  logic       clk,
    input  logic       erst,
    ssl_sched_if.slave bus
);

    localparam int                    NDATA_LOG = ndata_log(NDATA);
    localparam logic [NDATA_LOG-1:0]  LAST      = NDATA_LOG'(NDATA - 1);

    state_e                          state_q, state_d;
    logic [NDATA_LOG-1:0]            idx_q, idx_d, lag_q, lag_d;
    logic [1:0]                      pair_q, pair_d;
    logic                            drain_seen_q, drain_seen_d;
    logic [1:0]                      last_pair_q;
    logic [NDATA_LOG-1:0]            last_lag_q;
    logic [NDATA_LOG-1:0]            dA_q, dB_q, dC_q;
    logic [NPAIR-1:0][NDATA_LOG-1:0] best_lag;
    logic                            idx_end, lag_end, score_en, publish;

    assign idx_end  = (idx_q == LAST);
    assign lag_end  = (lag_q == LAST);
    assign score_en = bus.corr_valid && (state_q == S_SWEEP || state_q == S_DRAIN);
    assign publish  = (state_q == S_DRAIN) && (state_d == S_DONE);

    always_ff @(posedge clk or negedge erst) begin
        if (!erst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.start) state_d = S_CAPTURE;
            S_CAPTURE: if (idx_end) state_d = S_SWEEP;
            S_SWEEP:   if (idx_end && lag_end && pair_q == PAIR_C) state_d = S_DRAIN;
            S_DRAIN:   if (drain_seen_q) state_d = S_DONE;
            S_DONE:    if (bus.res_ready) state_d = bus.cont ? S_CAPTURE : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (bus.abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_comb begin
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.rd_addr  = '0;
        bus.lag      = '0;
        bus.pair_sel = PAIR_A;
        bus.acc_en   = 1'b0;
        bus.acc_clr  = 1'b0;
        bus.acc_last = 1'b0;
        bus.busy     = 1'b0;
        bus.res_valid = 1'b0;
        case (state_q)
            S_CAPTURE: begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = idx_q;
                bus.busy    = 1'b1;
            end
            S_SWEEP: begin
                bus.acc_en   = 1'b1;
                bus.rd_addr  = idx_q;
                bus.lag      = lag_q;
                bus.pair_sel = pair_q;
                bus.acc_clr  = (idx_q == '0);
                bus.acc_last = idx_end;
                bus.busy     = 1'b1;
            end
            S_DRAIN: bus.busy = 1'b1;
            S_DONE:  bus.res_valid = 1'b1;
            default: ;
        endcase
    end

    // Every state change restarts the counters, so each phase begins at 0.
    always_comb begin
        idx_d  = idx_q;
        lag_d  = lag_q;
        pair_d = pair_q;
        if (state_d != state_q) begin
            idx_d  = '0;
            lag_d  = '0;
            pair_d = PAIR_A;
        end else if (state_q == S_CAPTURE) begin
            idx_d = idx_q + 1'b1;
        end else if (state_q == S_SWEEP) begin
            idx_d = idx_q + 1'b1;
            if (idx_end) begin
                lag_d = lag_q + 1'b1;
                if (lag_end) pair_d = pair_q + 2'd1;
            end
        end
    end

    // The final score lands in DRAIN; one extra DRAIN cycle lets the best
    // registers settle before they are published on DONE entry.
    assign drain_seen_d = (state_q == S_DRAIN) && (state_d == S_DRAIN) && bus.corr_valid;

    always_ff @(posedge clk or negedge erst) begin
        if (!erst) begin
            idx_q        <= '0;
            lag_q        <= '0;
            pair_q       <= PAIR_A;
            drain_seen_q <= 1'b0;
            last_pair_q  <= PAIR_A;
            last_lag_q   <= '0;
            dA_q         <= '0;
            dB_q         <= '0;
            dC_q         <= '0;
        end else begin
            idx_q        <= idx_d;
            lag_q        <= lag_d;
            pair_q       <= pair_d;
            drain_seen_q <= drain_seen_d;
            if (state_q == S_SWEEP && idx_end) begin
                last_pair_q <= pair_q;
                last_lag_q  <= lag_q;
            end
            if (publish) begin
                dA_q <= best_lag[PAIR_A];
                dB_q <= best_lag[PAIR_B];
                dC_q <= best_lag[PAIR_C];
            end
        end
    end

    ssl_argmax #(.NL(NDATA_LOG), .SW(SW)) u_argmax (
        .clk          (clk),
        .erst         (erst),
        .corr_valid_i (score_en),
        .corr_score_i (bus.corr_score),
        .pair_d_i     (last_pair_q),
        .lag_d_i      (last_lag_q),
        .best_lag_o   (best_lag)
    );

    assign bus.dIdA = dA_q;
    assign bus.dIdB = dB_q;
    assign bus.dIdC = dC_q;

endmodule

// File: tb/tb_ssl_sched.sv
// Bench for ssl_sched with NDATA=8: table-driven correlator and argmax reference.
module tb_ssl_sched;
    import ssl_pkg::*;

    localparam int N   = 8;
    localparam int SWT = 16;
    localparam int NL  = 3;
    localparam int LAT = 1 + N + 3 * N * N + 2;

    logic clk = 1'b0;
    logic erst = 1'b0;

    ssl_sched_if #(.NDATA(N), .SW(SWT)) bus();
    ssl_sched #(.NDATA(N), .SW(SWT)) dut (.clk(clk), .erst(erst), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int tab [3][N];
    int wr_cnt = 0, sw_cnt = 0, last_cnt = 0, seq_err = 0;

    logic [25:0]   outs_all;
    logic [NL-1:0] did [3];
    assign outs_all = {bus.wr_en, bus.wr_addr, bus.rd_addr, bus.lag, bus.pair_sel, bus.acc_en,
                       bus.acc_clr, bus.acc_last, bus.busy, bus.res_valid,
                       bus.dIdA, bus.dIdB, bus.dIdC};
    assign did[0] = bus.dIdA;
    assign did[1] = bus.dIdB;
    assign did[2] = bus.dIdC;

    // First index of the maximum score: ties resolve to the lowest lag.
    function automatic int exp_lag(input int p);
        int b = 0;
        for (int l = 1; l < N; l++) if (tab[p][l] > tab[p][b]) b = l;
        return b;
    endfunction

    // Correlator stand-in: a score for the finished (pair, lag) one cycle after acc_last.
    initial begin
        logic          sl;
        logic [1:0]    sp;
        logic [NL-1:0] sg;
        bus.corr_valid = 1'b0;
        bus.corr_score = '0;
        forever begin
            @(negedge clk);
            sl = bus.acc_last;
            sp = bus.pair_sel;
            sg = bus.lag;
            @(posedge clk);
            #1;
            bus.corr_valid = sl;
            bus.corr_score = (sl && sp < 2'd3) ? SWT'(tab[sp][sg]) : '0;
        end
    end

    // Expected strobe sequence from frame-relative counts.
    initial forever begin
        @(negedge clk);
        if (bus.wr_en === 1'b1) begin
            if (int'(bus.wr_addr) != wr_cnt) seq_err++;
            wr_cnt++;
        end
        if (bus.acc_en === 1'b1) begin
            if (int'(bus.rd_addr) != sw_cnt % N || int'(bus.lag) != (sw_cnt / N) % N ||
                int'(bus.pair_sel) != sw_cnt / (N * N) ||
                bus.acc_clr !== (sw_cnt % N == 0) || bus.acc_last !== (sw_cnt % N == N - 1))
                seq_err++;
            sw_cnt++;
        end
        if (bus.acc_last === 1'b1) last_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        wr_cnt = 0; sw_cnt = 0; last_cnt = 0; seq_err = 0;
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int p = 0; p < 3; p++)
            for (int l = 0; l < N; l++)
                tab[p][l] = lo + int'($urandom_range(0, hi - lo));
    endtask

    // lat counts cycles with the start cycle as cycle 0.
    task automatic run_frame(output int lat);
        @(negedge clk); bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        clear_mon();
        lat = 1;
        while (bus.res_valid !== 1'b1 && lat < 400) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic accept();
        @(negedge clk); bus.res_ready = 1'b1;
        @(posedge clk); #1; bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        erst = 1'b0; #1;
        total++; if (outs_all !== '0) begin bad++; $display("FAIL reset_hold got=%h exp=0", outs_all); end
        #19; erst = 1'b1;
        for (int c = 0; c < 100; c++) begin
            bus.res_ready = 1'($urandom_range(0, 1));
            bus.cont      = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            total++; if (outs_all !== '0) begin bad++; $display("FAIL idle_outputs cyc=%0d got=%h exp=0", c, outs_all); end
        end
        bus.res_ready = 1'b0; bus.cont = 1'b0;
    endtask

    task automatic test_single_frame();
        int lat;
        for (int l = 0; l < N; l++) begin
            tab[0][l] = -((l > 3) ? l - 3 : 3 - l);
            tab[1][l] = -((l > 5) ? l - 5 : 5 - l);
            tab[2][l] = -l;
        end
        run_frame(lat);
        total++; if (lat != LAT) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", lat, LAT); end
        total++; if (bus.dIdA !== 3'd3) begin bad++; $display("FAIL single_dIdA got=%0d exp=3", bus.dIdA); end
        total++; if (bus.dIdB !== 3'd5) begin bad++; $display("FAIL single_dIdB got=%0d exp=5", bus.dIdB); end
        total++; if (bus.dIdC !== 3'd0) begin bad++; $display("FAIL single_dIdC got=%0d exp=0", bus.dIdC); end
        total++; if (wr_cnt != N) begin bad++; $display("FAIL single_wr_cycles got=%0d exp=%0d", wr_cnt, N); end
        total++; if (last_cnt != 3 * N) begin bad++; $display("FAIL single_acc_last got=%0d exp=%0d", last_cnt, 3 * N); end
        total++; if (sw_cnt != 3 * N * N) begin bad++; $display("FAIL single_acc_en got=%0d exp=%0d", sw_cnt, 3 * N * N); end
        total++; if (seq_err != 0) begin bad++; $display("FAIL single_sequence got=%0d errors exp=0", seq_err); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_done got=%b exp=0", bus.busy); end
        accept();
        total++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL single_accept got=%b%b exp=00", bus.res_valid, bus.busy); end
    endtask

    task automatic test_tie();
        int lat;
        fill_rand(-50, 50);
        for (int l = 0; l < N; l++) tab[0][l] = -7;
        run_frame(lat);
        total++; if (lat != LAT) begin bad++; $display("FAIL tie_const_latency got=%0d exp=%0d", lat, LAT); end
        for (int p = 0; p < 3; p++) begin
            total++; if (int'(did[p]) != exp_lag(p)) begin bad++; $display("FAIL tie_const_pair%0d got=%0d exp=%0d", p, did[p], exp_lag(p)); end
        end
        total++; if (bus.dIdA !== 3'd0) begin bad++; $display("FAIL tie_const_dIdA got=%0d exp=0", bus.dIdA); end
        accept();
        fill_rand(-20, 4);
        tab[0][2] = 5; tab[0][6] = 5;
        run_frame(lat);
        total++; if (bus.dIdA !== 3'd2) begin bad++; $display("FAIL tie_equal_dIdA got=%0d exp=2", bus.dIdA); end
        for (int p = 1; p < 3; p++) begin
            total++; if (int'(did[p]) != exp_lag(p)) begin bad++; $display("FAIL tie_equal_pair%0d got=%0d exp=%0d", p, did[p], exp_lag(p)); end
        end
        accept();
    endtask

    task automatic test_random();
        int lat;
        for (int f = 0; f < 4; f++) begin
            if (f[0]) fill_rand(-32768, 32767);
            else      fill_rand(-4, 3);
            run_frame(lat);
            total++; if (lat != LAT) begin bad++; $display("FAIL rand%0d_latency got=%0d exp=%0d", f, lat, LAT); end
            for (int p = 0; p < 3; p++) begin
                total++; if (int'(did[p]) != exp_lag(p)) begin bad++; $display("FAIL rand%0d_pair%0d got=%0d exp=%0d", f, p, did[p], exp_lag(p)); end
            end
            accept();
        end
    endtask

    task automatic test_handshake();
        int lat;
        logic [3*NL-1:0] snap;
        bus.cont = 1'b1;
        fill_rand(-100, 100);
        run_frame(lat);
        for (int p = 0; p < 3; p++) begin
            total++; if (int'(did[p]) != exp_lag(p)) begin bad++; $display("FAIL hs_first_pair%0d got=%0d exp=%0d", p, did[p], exp_lag(p)); end
        end
        snap = {did[0], did[1], did[2]};
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            total++;
            if (bus.res_valid !== 1'b1 || {did[0], did[1], did[2]} !== snap) begin
                bad++; $display("FAIL hs_hold cyc=%0d got=%b/%h exp=1/%h", c, bus.res_valid, {did[0], did[1], did[2]}, snap);
            end
        end
        fill_rand(-100, 100);
        @(negedge clk); bus.res_ready = 1'b1;
        @(posedge clk); #1; bus.res_ready = 1'b0;
        clear_mon();
        bus.cont = 1'b0;
        total++; if (bus.res_valid !== 1'b0 || bus.wr_en !== 1'b1) begin bad++; $display("FAIL hs_cont_restart got=%b%b exp=01", bus.res_valid, bus.wr_en); end
        lat = 1;
        while (bus.res_valid !== 1'b1 && lat < 400) begin @(posedge clk); #1; lat++; end
        total++; if (lat != LAT) begin bad++; $display("FAIL hs_cont_latency got=%0d exp=%0d", lat, LAT); end
        for (int p = 0; p < 3; p++) begin
            total++; if (int'(did[p]) != exp_lag(p)) begin bad++; $display("FAIL hs_cont_pair%0d got=%0d exp=%0d", p, did[p], exp_lag(p)); end
        end
        accept();
        total++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL hs_to_idle got=%b%b exp=00", bus.wr_en, bus.busy); end
    endtask

    task automatic test_abort();
        int lat, c;
        logic [3*NL-1:0] prev, pub;
        prev = {did[0], did[1], did[2]};
        fill_rand(-100, 100);
        @(negedge clk); bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        c = 0;
        while (!(bus.acc_en === 1'b1 && bus.pair_sel === 2'd1 && bus.lag === 3'd4) && c < 400) begin
            @(posedge clk); #1; c++;
        end
        total++; if (c >= 400) begin bad++; $display("FAIL abort_reach_point got=timeout exp=pair1_lag4"); end
        @(negedge clk); bus.abort = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1; bus.abort = 1'b0; bus.start = 1'b0;
        total++; if (bus.acc_en !== 1'b0 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
            bad++; $display("FAIL abort_sweep got=%b%b%b exp=000", bus.acc_en, bus.busy, bus.res_valid);
        end
        total++; if ({did[0], did[1], did[2]} !== prev) begin bad++; $display("FAIL abort_keep_dId got=%h exp=%h", {did[0], did[1], did[2]}, prev); end
        repeat (5) @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0 || {did[0], did[1], did[2]} !== prev) begin bad++; $display("FAIL abort_settled got=%b/%h exp=0/%h", bus.busy, {did[0], did[1], did[2]}, prev); end
        fill_rand(-100, 100);
        run_frame(lat);
        total++; if (lat != LAT) begin bad++; $display("FAIL abort_next_latency got=%0d exp=%0d", lat, LAT); end
        for (int p = 0; p < 3; p++) begin
            total++; if (int'(did[p]) != exp_lag(p)) begin bad++; $display("FAIL abort_next_pair%0d got=%0d exp=%0d", p, did[p], exp_lag(p)); end
        end
        pub = {did[0], did[1], did[2]};
        @(negedge clk); bus.abort = 1'b1; bus.res_ready = 1'b1; bus.cont = 1'b1;
        @(posedge clk); #1; bus.abort = 1'b0; bus.res_ready = 1'b0; bus.cont = 1'b0;
        total++; if (bus.res_valid !== 1'b0 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL abort_done got=%b%b%b exp=000", bus.res_valid, bus.wr_en, bus.busy);
        end
        total++; if ({did[0], did[1], did[2]} !== pub) begin bad++; $display("FAIL abort_done_dId got=%h exp=%h", {did[0], did[1], did[2]}, pub); end
    endtask

    task automatic test_async_reset();
        int lat;
        fill_rand(-100, 100);
        @(negedge clk); bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL arst_in_capture got=%b exp=1", bus.wr_en); end
        erst = 1'b0; #1;
        total++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL arst_immediate got=%b%b exp=00", bus.wr_en, bus.busy); end
        total++; if (outs_all !== '0) begin bad++; $display("FAIL arst_outputs got=%h exp=0", outs_all); end
        @(negedge clk); erst = 1'b1;
        run_frame(lat);
        total++; if (lat != LAT) begin bad++; $display("FAIL arst_next_latency got=%0d exp=%0d", lat, LAT); end
        total++; if (wr_cnt != N) begin bad++; $display("FAIL arst_next_wr got=%0d exp=%0d", wr_cnt, N); end
        for (int p = 0; p < 3; p++) begin
            total++; if (int'(did[p]) != exp_lag(p)) begin bad++; $display("FAIL arst_next_pair%0d got=%0d exp=%0d", p, did[p], exp_lag(p)); end
        end
        accept();
    endtask

    initial begin
        bus.start = 1'b0; bus.cont = 1'b0; bus.abort = 1'b0; bus.res_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_tie();
        test_random();
        test_handshake();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
